decode_stage: RTL
=================

# decode_stage

Instruction decode stage of the 5-stage pipeline, sitting between fetch and the ALU (execute). It accepts a 32-bit RV32I instruction and its PC from fetch, reads the 32×32 register file, and formats the control word, operands and immediate consumed by execute. It also owns the writeback port of the register file and the RAW-hazard interlock, which stalls fetch and inserts bubbles. The pipeline has no forwarding.

## Interface
Parameters:
- XLEN, 32, datapath width (only 32 supported)
- NREGS, 32, architectural register count

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- instr_in  in  32  instruction from fetch
- pc_in  in  32  PC of instr_in
- valid_in  in  1  instr_in is meaningful
- flush_in  in  1  taken branch/jump in execute; discard instr_in
- wb_en  in  1  register write enable from writeback
- wb_addr  in  5  destination register
- wb_data  in  32  write data
- stall_out  out  1  combinational; fetch must hold instr_in/pc_in
- c_d_e_out  out  32  control word: [6:0] opcode, [9:7] funct3, [16:10] funct7, [21:17] rd, [26:22] rs1, [31:27] rs2
- d1_out  out  32  rs1 value
- d2_out  out  32  rs2 value or immediate
- imm_out  out  32  branch/jump offset
- store_data_out  out  32  rs2 value for stores
- pc_out  out  32  PC of decoded instruction
- valid_out  out  1  outputs hold a real instruction; 0 = bubble

## Operation
- Register file: x0 reads 0; writes to x0 are ignored; write on rising edge when wb_en=1.
- Operand selection by opcode:
  - 0110011 (R-type): d1=rs1, d2=rs2.
  - 0010011, 0000011, 1100111: d1=rs1, d2=sext(I-imm).
  - 0100011 (store): d1=rs1, d2=sext(S-imm), store_data=rs2.
  - 1100011 (branch): d1=rs1, d2=rs2, imm=sext(B-imm).
  - 1101111 (jal): d1=d2=0, imm=sext(J-imm).
  - 1100111 (jalr): additionally imm=sext(I-imm).
  - 0110111 and 0010111 (lui/auipc): d1=0, d2=zero-extended instr[31:12]; execute applies the shift.
- imm_out is 0 for any opcode not listed above with an imm assignment. store_data_out is 0 for non-stores.
- rs1 is used by all opcodes except lui, auipc and jal. rs2 is used by R-type, store and branch.
- rd is written by R-type, I-ALU, load, jal, jalr, lui and auipc. rd=0 never counts as a writer.
- Illegal or unlisted opcode: decoded as a bubble (valid_out=0, all other outputs 0).
- Hazard tracker: a 3-entry shift register (EX, MEM, WB), each entry holding {writes_rd, rd}. It shifts every cycle; the new EX entry is the instruction issued this cycle, or empty for a bubble.
- Stall condition (combinational): stall_out=1 when valid_in=1, flush_in=0, and a used rs1/rs2 matches rd of a writing entry in a checked stage (see Configuration).
- Per-edge priority: reset > flush_in > stall > issue.
  - Flush and stall both produce a bubble.
  - Issue registers all outputs with valid_out=1.
- valid_in=0 produces a bubble, with stall_out=0.

## Timing
- Reset: all outputs 0 (including valid_out), tracker cleared, x0–x31 cleared. stall_out is 0 while reset=1.
- Latency: instr_in sampled at edge N appears on outputs after edge N.
- Outputs change only on the rising edge. stall_out is combinational from instr_in and the tracker.
- Back-to-back dependency (producer then consumer):
  - With the bypass: 2 bubble cycles.
  - Without the bypass: 3 bubble cycles.
- Simultaneous flush_in and stall: flush wins, stall_out=0, and the instruction is dropped.
- Reset asserted mid-stall: the stall clears on the next edge.

## Configuration
- REGFILE_BYPASS_EN, when defined:
  - A read of wb_addr (≠0) with wb_en=1 returns wb_data in the same cycle.
  - The stall check covers the EX and MEM entries only.
- When undefined:
  - Reads return the stored value.
  - The stall check covers EX, MEM and WB.

## Structure
- Shared package: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), control-word field bit positions, and immediate-extract functions.
- One sub-module, regfile: 2 read ports, 1 write port, with the optional bypass.

## Test plan
- Reset with garbage on instr_in: all outputs 0, stall_out=0. Then issue `addi x1,x0,5` (0x00500093): d1=0, d2=5, c_d_e_out[6:0]=0010011, rd=1, valid_out=1.
- Write x2=7 via wb, then `sub x3,x2,x2`: d1=d2=7, c_d_e_out[16:10]=0100000.
- `addi x1,x0,5` followed immediately by `add x4,x1,x1`: stall_out=1 for 2 cycles with bypass (3 without), bubbles inserted, then add issues with d1=d2=5 after writeback.
- `sw x5,8(x6)` with x5=0xAA, x6=0x100: d1=0x100, d2=8, store_data_out=0xAA. `lui x7,0x12345`: d2=0x12345.
- flush_in=1 during a stall on `add x4,x1,x1`: next outputs are a bubble, stall_out drops the same cycle, and the instruction is dropped.
- `beq x0,x0,-4`: d1=d2=0, imm_out=0xFFFFFFFC. `jal x1,2048`: imm_out=0x800, rd=1. Illegal opcode 0x0000007F produces a bubble.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage.
// Holds the opcode constants, control-word field positions, the hazard
// tracker entry type and the immediate-extract helpers.
package decode_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_AW  = 5;

  // Major opcodes handled by decode
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Control word layout handed to execute
  localparam int unsigned CW_OPCODE_LSB = 0;
  localparam int unsigned CW_FUNCT3_LSB = 7;
  localparam int unsigned CW_FUNCT7_LSB = 10;
  localparam int unsigned CW_RD_LSB     = 17;
  localparam int unsigned CW_RS1_LSB    = 22;
  localparam int unsigned CW_RS2_LSB    = 27;

  // One slot of the EX/MEM/WB destination tracker
  typedef struct packed {
    logic              writes_rd;
    logic [REG_AW-1:0] rd;
  } trk_entry_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // Upper immediate left unshifted; execute applies the shift
  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {12'b0, instr[31:12]};
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Architectural register file: 2 combinational read ports, 1 write port.
// x0 reads as zero and ignores writes. Synchronous active-high reset clears
// every register.
// Optional feature macro: REGFILE_BYPASS_EN -- a read of the register being
// written this cycle returns the write data instead of the stored value.
// Ports:
//   clk_i, rst_i            clock, synchronous reset
//   we_i, waddr_i, wdata_i  write port (writes on rising edge)
//   raddr1_i, rdata1_c_o    read port 1 (combinational)
//   raddr2_i, rdata2_c_o    read port 2 (combinational)
module decode_stage_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_c_o,
  output logic [XLEN-1:0] rdata2_c_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  // Storage update
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[AW'(i)] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports
  always_comb begin
    rdata1_c_o = (raddr1_i == '0) ? '0 : regs_q[raddr1_i];
    rdata2_c_o = (raddr2_i == '0) ? '0 : regs_q[raddr2_i];
`ifdef REGFILE_BYPASS_EN
    if (we_i && (waddr_i != '0) && (waddr_i == raddr1_i)) rdata1_c_o = wdata_i;
    if (we_i && (waddr_i != '0) && (waddr_i == raddr2_i)) rdata2_c_o = wdata_i;
`endif
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes instr_in, reads the register file, formats the
// control word / operands / immediate for execute, and interlocks RAW hazards
// (no forwarding) by stalling fetch and inserting bubbles.
// Optional feature macro: REGFILE_BYPASS_EN -- writeback data bypasses the
// register file in the same cycle, so the WB tracker slot is not checked.
// Ports:
//   clock, reset                        clock, synchronous active-high reset
//   instr_in, pc_in, valid_in           instruction from fetch
//   flush_in                            discard instr_in (redirect in execute)
//   wb_en, wb_addr, wb_data             register file write port
//   stall_out                           combinational; fetch holds instr_in
//   c_d_e_out, d1_out, d2_out, imm_out  registered control word and operands
//   store_data_out, pc_out, valid_out   registered store data, PC, valid
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            valid_in,
  input  logic            flush_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_out,
  output logic [31:0]     c_d_e_out,
  output logic [XLEN-1:0] d1_out,
  output logic [XLEN-1:0] d2_out,
  output logic [XLEN-1:0] imm_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [XLEN-1:0] pc_out,
  output logic            valid_out
);

`ifdef REGFILE_BYPASS_EN
  localparam logic CHECK_WB = 1'b0;
`else
  localparam logic CHECK_WB = 1'b1;
`endif

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [REG_AW-1:0] rd, rs1, rs2;

  assign opcode = instr_in[6:0];
  assign rd     = instr_in[11:7];
  assign funct3 = instr_in[14:12];
  assign rs1    = instr_in[19:15];
  assign rs2    = instr_in[24:20];
  assign funct7 = instr_in[31:25];

  logic [XLEN-1:0] rs1_data, rs2_data;

  decode_stage_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i      (clock),
    .rst_i      (reset),
    .we_i       (wb_en),
    .waddr_i    (wb_addr),
    .wdata_i    (wb_data),
    .raddr1_i   (rs1),
    .raddr2_i   (rs2),
    .rdata1_c_o (rs1_data),
    .rdata2_c_o (rs2_data)
  );

  // Opcode decode and operand selection
  logic            legal_c, uses_rs1_c, uses_rs2_c, writes_rd_c;
  logic [31:0]     cw_c;
  logic [XLEN-1:0] d1_c, d2_c, imm_c, sd_c;

  always_comb begin
    legal_c     = 1'b0;
    uses_rs1_c  = 1'b0;
    uses_rs2_c  = 1'b0;
    writes_rd_c = 1'b0;
    d1_c        = '0;
    d2_c        = '0;
    imm_c       = '0;
    sd_c        = '0;
    cw_c        = '0;
    cw_c[CW_OPCODE_LSB +: 7] = opcode;
    cw_c[CW_FUNCT3_LSB +: 3] = funct3;
    cw_c[CW_FUNCT7_LSB +: 7] = funct7;
    cw_c[CW_RD_LSB     +: 5] = rd;
    cw_c[CW_RS1_LSB    +: 5] = rs1;
    cw_c[CW_RS2_LSB    +: 5] = rs2;
    case (opcode)
      OP_R: begin
        legal_c = 1'b1; uses_rs1_c = 1'b1; uses_rs2_c = 1'b1; writes_rd_c = 1'b1;
        d1_c = rs1_data;
        d2_c = rs2_data;
      end
      OP_IMM, OP_LOAD: begin
        legal_c = 1'b1; uses_rs1_c = 1'b1; writes_rd_c = 1'b1;
        d1_c = rs1_data;
        d2_c = imm_i(instr_in);
      end
      OP_JALR: begin
        legal_c = 1'b1; uses_rs1_c = 1'b1; writes_rd_c = 1'b1;
        d1_c  = rs1_data;
        d2_c  = imm_i(instr_in);
        imm_c = imm_i(instr_in);
      end
      OP_STORE: begin
        legal_c = 1'b1; uses_rs1_c = 1'b1; uses_rs2_c = 1'b1;
        d1_c = rs1_data;
        d2_c = imm_s(instr_in);
        sd_c = rs2_data;
      end
      OP_BRANCH: begin
        legal_c = 1'b1; uses_rs1_c = 1'b1; uses_rs2_c = 1'b1;
        d1_c  = rs1_data;
        d2_c  = rs2_data;
        imm_c = imm_b(instr_in);
      end
      OP_JAL: begin
        legal_c = 1'b1; writes_rd_c = 1'b1;
        imm_c = imm_j(instr_in);
      end
      OP_LUI, OP_AUIPC: begin
        legal_c = 1'b1; writes_rd_c = 1'b1;
        d2_c = imm_u(instr_in);
      end
      default: ;
    endcase
  end

  // Hazard tracker: EX -> MEM -> WB
  trk_entry_t ex_q, mem_q, wb_q, ex_d;

  function automatic logic trk_hit(input trk_entry_t e, input logic [REG_AW-1:0] r);
    return e.writes_rd && (e.rd == r);
  endfunction

  function automatic logic src_hazard(input trk_entry_t ex, input trk_entry_t mem,
                                      input trk_entry_t wb, input logic [REG_AW-1:0] r);
    return trk_hit(ex, r) || trk_hit(mem, r) || (CHECK_WB && trk_hit(wb, r));
  endfunction

  logic raw_c, issue_c;

  always_comb begin
    raw_c = (uses_rs1_c && src_hazard(ex_q, mem_q, wb_q, rs1)) ||
            (uses_rs2_c && src_hazard(ex_q, mem_q, wb_q, rs2));
    issue_c = valid_in && !flush_in && !raw_c && legal_c;
    ex_d = '0;
    if (issue_c) begin
      // rd=0 never counts as a writer
      ex_d.writes_rd = writes_rd_c && (rd != '0);
      ex_d.rd        = rd;
    end
  end

  // Reset gates the stall so fetch is released while the tracker clears
  assign stall_out = !reset && valid_in && !flush_in && raw_c;

  // Output and tracker registers; anything not issued becomes a bubble
  logic [31:0]     cw_q;
  logic [XLEN-1:0] d1_q, d2_q, imm_q, sd_q, pc_q;
  logic            valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      cw_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      imm_q   <= '0;
      sd_q    <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      cw_q    <= issue_c ? cw_c  : '0;
      d1_q    <= issue_c ? d1_c  : '0;
      d2_q    <= issue_c ? d2_c  : '0;
      imm_q   <= issue_c ? imm_c : '0;
      sd_q    <= issue_c ? sd_c  : '0;
      pc_q    <= issue_c ? pc_in : '0;
      valid_q <= issue_c;
    end
  end

  assign c_d_e_out      = cw_q;
  assign d1_out         = d1_q;
  assign d2_out         = d2_q;
  assign imm_out        = imm_q;
  assign store_data_out = sd_q;
  assign pc_out         = pc_q;
  assign valid_out      = valid_q;

endmodule
